// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit:
//   fetch_state_e    - fetch FSM states
//   NOP_INSTR        - instruction word presented while the IF/ID slot is empty
//                      after reset
//   DEFAULT_RESET_PC - default PC loaded on reset
//   INSTR_W          - instruction word width
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0]        DEFAULT_RESET_PC = 32'h0000_0000;

    // S_REQ     : request driven whenever the output slot can take a word
    // S_WAIT    : output slot full, no request
    // S_DISCARD : a redirect left a request in flight; drop its response
    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/fetch_skid_buf.sv
// ----------------------------------------------------------------------------
// fetch_skid_buf
// Two-entry FIFO placed at the fetch output so a one-cycle decode stall does
// not create a bubble. Only instantiated when FETCH_SKID_EN is defined.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   flush                 - drop both entries (redirect)
//   in_valid / in_ready   - write side handshake, in_data payload
//   out_valid / out_ready - read side handshake, out_data = head entry
// in_ready depends only on the stored count, never on out_ready, so the
// fetch request path has no combinational dependency on decode.
// ----------------------------------------------------------------------------
module fetch_skid_buf #(
    parameter int unsigned       DATA_W     = 64,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q,  count_d;
    logic              push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];

    assign push = in_valid  && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: the storage is reset as well, because the head entry is visible
    // on the outputs while empty and must read as NOP / zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= RESET_DATA;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : fetch_skid_buf

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: holds the PC, issues word-aligned requests to the
// instruction memory and presents fetched words to decode with a valid/ready
// handshake. Memory acknowledges and returns data in the request cycle; the
// word appears on id_instr the following cycle.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   imem_req / imem_addr       - fetch request and word address (= PC)
//   imem_ack / imem_rdata      - same-cycle accept and instruction data
//   redir_valid / redir_pc     - one-cycle redirect (branch/jump)
//   id_valid / id_ready        - IF/ID handshake
//   id_instr / id_pc4          - instruction and its fetch address + 4
// Configuration macro:
//   FETCH_SKID_EN - replaces the single IF/ID register with a two-entry
//                   skid buffer (fetch_skid_buf) so fetch keeps going while
//                   the buffer has room.
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC[ADDR_W-1:0]
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redir_valid,
    input  logic [ADDR_W-1:0]  redir_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc4
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] redir_target;

    logic req_int;     // request actually driven this cycle
    logic accept;      // acked response that is written to the output
    logic slot_free;   // output can take a word this cycle
    logic wait_exit;   // S_WAIT may resume requesting

    // Wraps modulo 2^ADDR_W by construction.
    assign pc_plus4     = pc_q + ADDR_W'(4);
    assign redir_target = redir_pc & ~ADDR_W'(3);

    assign accept = req_int && imem_ack && !redir_valid;

`ifdef FETCH_SKID_EN
    logic buf_in_ready;
    logic buf_out_valid;
    logic [INSTR_W+ADDR_W-1:0] buf_out_data;

    fetch_skid_buf #(
        .DATA_W     (INSTR_W + ADDR_W),
        .RESET_DATA ({NOP_INSTR, {ADDR_W{1'b0}}})
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redir_valid),
        .in_valid  (accept),
        .in_ready  (buf_in_ready),
        .in_data   ({imem_rdata, pc_plus4}),
        .out_valid (buf_out_valid),
        .out_ready (id_ready),
        .out_data  (buf_out_data)
    );

    assign slot_free = buf_in_ready;
    assign wait_exit = buf_in_ready;

    assign id_valid  = buf_out_valid;
    assign id_instr  = buf_out_data[INSTR_W+ADDR_W-1:ADDR_W];
    assign id_pc4    = buf_out_data[ADDR_W-1:0];
`else
    logic               id_valid_q, id_valid_d;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic [ADDR_W-1:0]  id_pc4_q,   id_pc4_d;

    // The slot counts as free when it is emptying this cycle.
    assign slot_free = !id_valid_q || id_ready;
    assign wait_exit = id_valid_q && id_ready;

    always_comb begin
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc4_d   = id_pc4_q;
        if (id_valid_q && id_ready) begin
            id_valid_d = 1'b0;
        end
        if (accept) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc4_d   = pc_plus4;
        end
        // Redirect flushes the slot whatever decode is doing.
        if (redir_valid) begin
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            id_pc4_q   <= '0;
        end else begin
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc4_q   <= id_pc4_d;
        end
    end

    assign id_valid = id_valid_q;
    assign id_instr = id_instr_q;
    assign id_pc4   = id_pc4_q;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: all state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state (redirect has priority over ack, ready and stall)
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;

        if (redir_valid) begin
            pc_d = redir_target;
        end else if (accept) begin
            pc_d = pc_plus4;
        end

        unique case (state_q)
            S_REQ: begin
                if (redir_valid) begin
                    // An un-acked request is still owed a response.
                    state_d = (req_int && !imem_ack) ? S_DISCARD : S_REQ;
                end else if (!slot_free) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redir_valid || wait_exit) begin
                    state_d = S_REQ;
                end
            end
            S_DISCARD: begin
                // The stale response is dropped here; a redirect in this
                // state only moves the PC.
                if (imem_ack) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // Gated by rst_n so no request is visible while reset is asserted,
    // yet one goes out in the very first clock after release.
    always_comb begin
        req_int = 1'b0;
        if (rst_n && (state_q == S_REQ) && slot_free) begin
            req_int = 1'b1;
        end
    end

    assign imem_req  = req_int;
    assign imem_addr = pc_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
// Directed, table-driven bench for fetch_unit (default build, no skid
// buffer). Each table row gives the inputs for one clock cycle and the
// outputs expected during that cycle; rows are applied at the falling edge
// and outputs compared 1 ns later. Reset behaviour is covered by short
// hand-written sequences around the table.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;

    int checks;
    int failures;

    fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_valid, input logic [31:0] e_instr,
                                 input logic [31:0] e_pc4);
        check({tag, ".imem_req"},  {31'd0, imem_req}, {31'd0, e_req});
        check({tag, ".imem_addr"}, imem_addr,         e_addr);
        check({tag, ".id_valid"},  {31'd0, id_valid}, {31'd0, e_valid});
        check({tag, ".id_instr"},  id_instr,          e_instr);
        check({tag, ".id_pc4"},    id_pc4,            e_pc4);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // ack, rdy, rv, rpc, rdata | req, addr, valid, instr, pc4
        // Sequential fetch 0,4,8 with one-cycle latency
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h1111_0000, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h1111_0004, 1'b1, 32'h0000_0004, 1'b1, 32'h1111_0000, 32'h0000_0004};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h1111_0008, 1'b1, 32'h0000_0008, 1'b1, 32'h1111_0004, 32'h0000_0008};
        // id_ready low three cycles: output holds, no request, ack ignored
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h1111_000C, 1'b0, 32'h0000_000C, 1'b1, 32'h1111_0008, 32'h0000_000C};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h1111_000C, 1'b0, 32'h0000_000C, 1'b1, 32'h1111_0008, 32'h0000_000C};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h1111_000C, 1'b0, 32'h0000_000C, 1'b1, 32'h1111_0008, 32'h0000_000C};
        // Ready returns in S_WAIT: transfer, still no request this cycle
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h1111_000C, 1'b0, 32'h0000_000C, 1'b1, 32'h1111_0008, 32'h0000_000C};
        // Back in S_REQ: PC advanced by exactly one word across the stall
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h1111_000C, 1'b1, 32'h0000_000C, 1'b0, 32'h1111_0008, 32'h0000_000C};
        // Redirect to 0x43 with no ack: flush, then discard the next ack
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0043, 32'h0, 1'b1, 32'h0000_0010, 1'b1, 32'h1111_000C, 32'h0000_0010};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0040, 1'b0, 32'h1111_000C, 32'h0000_0010};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h2222_0040, 1'b1, 32'h0000_0040, 1'b0, 32'h1111_000C, 32'h0000_0010};
        // Redirect together with ack: response dropped, fetch at target
        vecs[11] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hBAD0_0044, 1'b1, 32'h0000_0044, 1'b1, 32'h2222_0040, 32'h0000_0044};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h3333_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h2222_0040, 32'h0000_0044};
        // PC wrap: id_pc4 = 0, next fetch at 0
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 32'h3333_FFFC, 32'h0000_0000};
        // Empty slot requests even with id_ready low, then stalls
        vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h4444_0000, 1'b1, 32'h0000_0000, 1'b0, 32'h3333_FFFC, 32'h0000_0000};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0000_0004, 1'b1, 32'h4444_0000, 32'h0000_0004};

        // Reset state
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        redir_valid = 1'b0;
        redir_pc    = 32'h0;
        id_ready    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

        // Release at a falling edge; the next rising edge is the first clock
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            if (i != 0) @(negedge clk);
            imem_ack    = vecs[i].ack;
            id_ready    = vecs[i].rdy;
            redir_valid = vecs[i].rv;
            redir_pc    = vecs[i].rpc;
            imem_rdata  = vecs[i].rdata;
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                          vecs[i].exp_valid, vecs[i].exp_instr, vecs[i].exp_pc4);
        end

        // Reset asserted mid-stall (id_valid=1, PC=4): takes effect at once
        @(negedge clk);
        imem_ack    = 1'b0;
        id_ready    = 1'b0;
        redir_valid = 1'b0;
        rst_n       = 1'b0;
        #1;
        check_outputs("midrst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

        // Release: request at RESET_PC before the first clock edge
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        id_ready   = 1'b1;
        imem_rdata = 32'h5555_0000;
        #1;
        check_outputs("rel0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        #1;
        check_outputs("rel1", 1'b1, 32'h4, 1'b1, 32'h5555_0000, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset (bits [1:0] SHALL be 0).
REQ-002 Parameter ADDR_W, default 32, PC and instruction-memory address width.
REQ-003 clk  input  1  single clock, all state rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  ADDR_W  word-aligned fetch address (equals PC).
REQ-007 imem_ack  input  1  memory accepts request and returns imem_rdata in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 redir_valid  input  1  one-cycle redirect pulse (taken branch or jump).
REQ-010 redir_pc  input  ADDR_W  redirect target; bits [1:0] ignored and forced to 0.
REQ-011 id_valid  output  1  IF/ID register holds a valid instruction.
REQ-012 id_ready  input  1  decode stage (opcode to control unit) accepts id_instr.
REQ-013 id_instr  output  32  instruction; bits [31:26] feed the control-unit opcode.
REQ-014 id_pc4  output  ADDR_W  fetch address + 4 of id_instr.

Function
REQ-015 FSM states: S_REQ (imem_req driven), S_WAIT (output full, no request), S_DISCARD (drop one stale response).
REQ-016 S_REQ: imem_req=1 while output slot free or emptying this cycle (id_valid & id_ready); otherwise go to S_WAIT.
REQ-017 imem_ack in S_REQ without redirect: id_instr<=imem_rdata, id_pc4<=PC+4, id_valid<=1, PC<=PC+4 next cycle.
REQ-018 Latency: instruction acked in cycle N is visible on id_instr in cycle N+1.
REQ-019 PC+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-020 Handshake: transfer when id_valid & id_ready; while id_valid & !id_ready, id_instr/id_pc4 SHALL hold stable.
REQ-021 S_WAIT -> S_REQ when id_ready asserted with id_valid.
REQ-022 redir_valid: PC<=redir_pc, id_valid<=0 (flush) next cycle, regardless of id_ready.
REQ-023 Redirect with request outstanding and no imem_ack that cycle -> S_DISCARD; the next imem_ack SHALL be dropped, then S_REQ at new PC.
REQ-024 Redirect and imem_ack in the same cycle: response dropped, PC<=redir_pc, remain S_REQ.
REQ-025 Redirect has priority over ack, id_ready and stall.
REQ-026 imem_req SHALL NOT be asserted in S_DISCARD for a new address until the stale response is dropped.

Reset
REQ-027 rst_n low: PC=RESET_PC, state=S_REQ, id_valid=0, id_instr=32'h0 (NOP), id_pc4=0, imem_req=0.
REQ-028 First imem_req=1 in the first clock after rst_n deasserts; reset mid-fetch discards any outstanding request.

Configuration
REQ-029 Macro FETCH_SKID_EN defined: a 2-entry skid buffer sits at the output; fetch continues while buffer not full, so id_ready low for one cycle causes no bubble; redirect flushes both entries.
REQ-030 FETCH_SKID_EN undefined: single IF/ID register, behaviour exactly per REQ-016..REQ-021.

Structure
REQ-031 Shared package fetch_pkg: FSM state enum, NOP constant 32'h0000_0000, default RESET_PC.
REQ-032 Sub-module fetch_skid_buf (2-entry, valid/ready in and out, flush input), instantiated only under FETCH_SKID_EN.

Verification
REQ-033 Reset release, imem_ack always 1, id_ready 1 -> imem_addr 0,4,8,...; id_instr one cycle after each ack; id_pc4 = addr+4.
REQ-034 id_ready low 3 cycles with id_valid=1 -> id_instr stable; without skid imem_req=0 in S_WAIT; PC advances by exactly one word per accepted instruction.
REQ-035 redir_valid with redir_pc=32'h0000_0043 while imem_ack=0 -> id_valid=0 next cycle; next ack dropped; following imem_addr=32'h0000_0040.
REQ-036 redir_valid and imem_ack same cycle -> that rdata never on id_instr; next imem_addr=redir_pc.
REQ-037 PC=32'hFFFF_FFFC, ack -> id_pc4=0, next imem_addr=0.
REQ-038 rst_n asserted mid-stall with id_valid=1 -> immediately id_valid=0, imem_req=0; after release imem_addr=RESET_PC.
